piso_serializer: RTL

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, a downstream shift-enable, selectable bit order and a last-bit marker. It converts a WIDTH-bit word into WIDTH serial bits, one bit per accepted shift cycle. A new word can be loaded in the same cycle the previous word's last bit leaves, so streaming is gap-free. It sits between a word-oriented producer and a bit-serial link or output pin.

---
 rtl/piso_pkg.sv | 7 +
 rtl/piso_serializer.sv | 71 +++++++
 2 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and counter-width helper for the PISO serializer
package piso_pkg;
    typedef enum logic {PISO_IDLE, PISO_SHIFT} piso_state_e;
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out with valid/ready load, shift enable and last-bit marker
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_out,
    output logic             ser_last,
    output logic             busy
);
    localparam int CW = cnt_w(WIDTH);
    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_last_q, ser_last_d;
    logic             ser_out_q, ser_out_d;
    logic             load, shift;
    assign load_ready = (state_q == PISO_IDLE) | (state_q == PISO_SHIFT & cnt_q == '0 & ser_ready);
    assign load       = load_valid & load_ready;
    assign shift      = (state_q == PISO_SHIFT) & ser_ready & (cnt_q != '0);
    // Outputs are precomputed from next state so they leave the block straight from flops
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = PISO_SHIFT;
            shreg_d = load_data;
            cnt_d   = CW'(WIDTH - 1);
        end else if (shift) begin
            shreg_d = MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
            cnt_d   = cnt_q - CW'(1);
        end else if (state_q == PISO_SHIFT && ser_ready) begin
            state_d = PISO_IDLE;
        end
        ser_valid_d = state_d == PISO_SHIFT;
        ser_last_d  = (state_d == PISO_SHIFT) & (cnt_d == '0);
        ser_out_d   = (state_d == PISO_SHIFT) ? (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]) : IDLE_LEVEL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PISO_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            ser_out_q   <= IDLE_LEVEL;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
            ser_out_q   <= ser_out_d;
        end
    end
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;
    assign ser_out   = ser_out_q;
    assign busy      = ser_valid_q;
endmodule
